// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Request/response channel between memory-stage requester and the
//            data-memory responder (valid/ready on both directions).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
    parameter int W  = 16,
    parameter int AW = 11
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_write;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_write
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_write
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory target with a fixed wait-state
//            latency; one W-bit word per access, word addressed.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int W           = 16,
    parameter int AW          = 11,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output logic              busy
);

    localparam int unsigned c_DEPTH    = 2**AW;
    localparam logic [3:0]  c_LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [3:0]  c_DONE_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [W-1:0]  r_wdata;
    logic [W-1:0]  r_rdata;
    logic          r_write;
    logic [W-1:0]  r_mem [c_DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic          w_cmt_we;
    logic [AW-1:0] w_cmt_addr;
    logic [W-1:0]  w_cmt_wdata;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    // With no wait states the commit happens on the accept edge itself, so the
    // commit operands come straight from the request inputs in that build.
    assign w_commit    = !rst && ((WAIT_CYCLES == 0) ? w_accept
                                  : ((r_state == S_WAIT) && (r_cnt == c_LAST_CNT)));
    assign w_cmt_we    = (WAIT_CYCLES == 0) ? bus.req_we    : r_we;
    assign w_cmt_addr  = (WAIT_CYCLES == 0) ? bus.req_addr  : r_addr;
    assign w_cmt_wdata = (WAIT_CYCLES == 0) ? bus.req_wdata : r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)              w_state_next = S_WAIT;
            S_WAIT:  if (r_cnt == c_DONE_CNT)   w_state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready)         w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_write <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'd0;
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_commit) begin
                r_rdata <= w_cmt_we ? '0 : r_mem[w_cmt_addr];
                r_write <= w_cmt_we;
            end
        end
    end

    // Storage contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_cmt_we) begin
            r_mem[w_cmt_addr] <= w_cmt_wdata;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_write = r_write;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire
